// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: DEPTH back-to-back control stages with stall/flush/bubble handling
// and a youngest-producer forwarding query. Optional stall-bubble counter: CTRL_PIPE_PERF_EN.
module ctrl_pipe_chain #(
    parameter int DEPTH    = 2,
    parameter int CTRL_W   = 3,
    parameter int TNEW_W   = 3,
    parameter int RD_W     = 5,
    parameter int REGW_BIT = 0
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       in_valid,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [TNEW_W-1:0]          in_tnew,
    input  logic [RD_W-1:0]            in_rd,
    input  logic [DEPTH-1:0]           stall_i,
    input  logic [DEPTH-1:0]           flush_i,
    input  logic [RD_W-1:0]            q_rs,
    output logic [DEPTH-1:0]           valid_o,
    output logic [DEPTH*CTRL_W-1:0]    ctrl_o,
    output logic [DEPTH*TNEW_W-1:0]    tnew_o,
    output logic [DEPTH*RD_W-1:0]      rd_o,
    output logic                       hit_o,
    output logic [$clog2(DEPTH):0]     hit_stage_o,
    output logic                       hit_ready_o
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]                bubble_cnt_o
`endif
);

    localparam int HIT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]             valid_w;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_w;
    logic [DEPTH-1:0][TNEW_W-1:0] tnew_w;
    logic [DEPTH-1:0][RD_W-1:0]   rd_w;
    logic [DEPTH-1:0]             match_w;
`ifdef CTRL_PIPE_PERF_EN
    logic [DEPTH-1:0]             stall_bubble_w;
`endif

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic              src_valid;
        logic [CTRL_W-1:0] src_ctrl;
        logic [TNEW_W-1:0] src_tnew;
        logic [RD_W-1:0]   src_rd;
        logic              older_held;

        logic              valid_q, valid_d;
        logic [CTRL_W-1:0] ctrl_q, ctrl_d;
        logic [TNEW_W-1:0] tnew_q, tnew_d;
        logic [RD_W-1:0]   rd_q, rd_d;

        if (gi == 0) begin : g_head
            assign src_valid  = in_valid;
            assign src_ctrl   = in_ctrl;
            assign src_tnew   = in_tnew;
            assign src_rd     = in_rd;
            assign older_held = 1'b0;
        end else begin : g_body
            assign src_valid  = valid_w[gi-1];
            assign src_ctrl   = ctrl_w[gi-1];
            assign src_tnew   = tnew_w[gi-1];
            assign src_rd     = rd_w[gi-1];
            assign older_held = stall_i[gi-1];
        end

        always_comb begin
            valid_d = src_valid;
            ctrl_d  = src_ctrl;
            rd_d    = src_rd;
            tnew_d  = (src_tnew == '0) ? '0 : src_tnew - TNEW_W'(1);
            if (flush_i[gi]) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                tnew_d  = '0;
                rd_d    = '0;
            end else if (stall_i[gi]) begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
                tnew_d  = tnew_q;
                rd_d    = rd_q;
            end else if (older_held) begin
                // Younger neighbour is frozen, so nothing real arrives here this cycle.
                valid_d = 1'b0;
                ctrl_d  = '0;
                tnew_d  = '0;
                rd_d    = '0;
            end
        end

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                tnew_q  <= '0;
                rd_q    <= '0;
            end else begin
                valid_q <= valid_d;
                ctrl_q  <= ctrl_d;
                tnew_q  <= tnew_d;
                rd_q    <= rd_d;
            end
        end

        assign valid_w[gi] = valid_q;
        assign ctrl_w[gi]  = ctrl_q;
        assign tnew_w[gi]  = tnew_q;
        assign rd_w[gi]    = rd_q;
        assign match_w[gi] = valid_q && ctrl_q[REGW_BIT] && (rd_q == q_rs) && (q_rs != '0);
`ifdef CTRL_PIPE_PERF_EN
        assign stall_bubble_w[gi] = older_held && !stall_i[gi] && !flush_i[gi];
`endif
    end

    assign valid_o = valid_w;
    assign ctrl_o  = ctrl_w;
    assign tnew_o  = tnew_w;
    assign rd_o    = rd_w;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_o       = 1'b0;
        hit_stage_o = '0;
        hit_ready_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_w[k]) begin
                hit_o       = 1'b1;
                hit_stage_o = HIT_W'(k);
                hit_ready_o = (tnew_w[k] == '0);
            end
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((|stall_bubble_w) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain: directed hazard scenarios followed by random
// traffic, checked against an instruction-level model of the pipeline.
module tb_ctrl_pipe_chain;

    localparam int DEPTH    = 3;
    localparam int CTRL_W   = 3;
    localparam int TNEW_W   = 3;
    localparam int RD_W     = 5;
    localparam int REGW_BIT = 1;
    localparam int HIT_W    = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    clr_n = 1'b0;
    logic                    in_valid;
    logic [CTRL_W-1:0]       in_ctrl;
    logic [TNEW_W-1:0]       in_tnew;
    logic [RD_W-1:0]         in_rd;
    logic [DEPTH-1:0]        stall_i;
    logic [DEPTH-1:0]        flush_i;
    logic [RD_W-1:0]         q_rs;
    logic [DEPTH-1:0]        valid_o;
    logic [DEPTH*CTRL_W-1:0] ctrl_o;
    logic [DEPTH*TNEW_W-1:0] tnew_o;
    logic [DEPTH*RD_W-1:0]   rd_o;
    logic                    hit_o;
    logic [HIT_W-1:0]        hit_stage_o;
    logic                    hit_ready_o;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0]             bubble_cnt_o;
`endif

    always #5 clk = ~clk;

    ctrl_pipe_chain #(
        .DEPTH(DEPTH), .CTRL_W(CTRL_W), .TNEW_W(TNEW_W), .RD_W(RD_W), .REGW_BIT(REGW_BIT)
    ) dut (
        .clk(clk), .clr_n(clr_n),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_tnew(in_tnew), .in_rd(in_rd),
        .stall_i(stall_i), .flush_i(flush_i), .q_rs(q_rs),
        .valid_o(valid_o), .ctrl_o(ctrl_o), .tnew_o(tnew_o), .rd_o(rd_o),
        .hit_o(hit_o), .hit_stage_o(hit_stage_o), .hit_ready_o(hit_ready_o)
`ifdef CTRL_PIPE_PERF_EN
        , .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    // Model: each slot holds an instruction record; Tnew is derived from how many
    // times the record has advanced since issue.
    typedef struct {
        bit                v;
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        int                tnew0;
        int                steps;
    } instr_t;

    typedef struct {
        logic [DEPTH-1:0]        valid;
        logic [DEPTH*CTRL_W-1:0] ctrl;
        logic [DEPTH*TNEW_W-1:0] tnew;
        logic [DEPTH*RD_W-1:0]   rd;
        logic                    hit;
        logic [HIT_W-1:0]        hit_stage;
        logic                    hit_ready;
        logic [31:0]             bcnt;
    } exp_t;

    instr_t      pipe [DEPTH];
    exp_t        sb [$];
    logic [31:0] model_bcnt = '0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk_bubble();
        instr_t b;
        b.v = 1'b0; b.ctrl = '0; b.rd = '0; b.tnew0 = 0; b.steps = 0;
        return b;
    endfunction

    function automatic int exp_tnew(input instr_t s);
        return (s.tnew0 > s.steps) ? (s.tnew0 - s.steps) : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) pipe[k] = mk_bubble();
        model_bcnt = '0;
    endtask

    task automatic model_step(input bit vld, input logic [CTRL_W-1:0] c, input int tn,
                              input logic [RD_W-1:0] r, input logic [DEPTH-1:0] st,
                              input logic [DEPTH-1:0] fl);
        instr_t nxt [DEPTH];
        instr_t src;
        bit     stall_bubble = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (fl[k]) begin
                nxt[k] = mk_bubble();
            end else if (st[k]) begin
                nxt[k] = pipe[k];
            end else if (k > 0 && st[k-1]) begin
                nxt[k] = mk_bubble();
                stall_bubble = 1'b1;
            end else begin
                if (k == 0) begin
                    src.v = vld; src.ctrl = c; src.rd = r; src.tnew0 = tn; src.steps = 0;
                end else begin
                    src = pipe[k-1];
                end
                src.steps++;
                nxt[k] = src;
            end
        end
        for (int k = 0; k < DEPTH; k++) pipe[k] = nxt[k];
        if (stall_bubble && model_bcnt != 32'hFFFF_FFFF) model_bcnt++;
    endtask

    function automatic exp_t snapshot(input logic [RD_W-1:0] q);
        exp_t e;
        e.hit = 1'b0; e.hit_stage = '0; e.hit_ready = 1'b0; e.bcnt = model_bcnt;
        for (int k = 0; k < DEPTH; k++) begin
            e.valid[k]                  = pipe[k].v;
            e.ctrl[k*CTRL_W +: CTRL_W]  = pipe[k].ctrl;
            e.tnew[k*TNEW_W +: TNEW_W]  = TNEW_W'(exp_tnew(pipe[k]));
            e.rd[k*RD_W +: RD_W]        = pipe[k].rd;
            if (!e.hit && pipe[k].v && pipe[k].ctrl[REGW_BIT] && pipe[k].rd == q && q != '0) begin
                e.hit       = 1'b1;
                e.hit_stage = HIT_W'(k);
                e.hit_ready = (exp_tnew(pipe[k]) == 0);
            end
        end
        return e;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_ctrl"},  64'(ctrl_o),  64'd0);
        chk({tag, "_tnew"},  64'(tnew_o),  64'd0);
        chk({tag, "_rd"},    64'(rd_o),    64'd0);
        chk({tag, "_hit"},   64'(hit_o),   64'd0);
`ifdef CTRL_PIPE_PERF_EN
        chk({tag, "_bcnt"},  64'(bubble_cnt_o), 64'd0);
`endif
    endtask

    // One clock of stimulus; optionally pulses clr_n between edges.
    task automatic cycle(input bit vld, input logic [CTRL_W-1:0] c, input int tn,
                         input logic [RD_W-1:0] r, input logic [DEPTH-1:0] st,
                         input logic [DEPTH-1:0] fl, input logic [RD_W-1:0] q,
                         input bit do_rst);
        @(negedge clk);
        in_valid = vld; in_ctrl = c; in_tnew = TNEW_W'(tn); in_rd = r;
        stall_i = st; flush_i = fl; q_rs = q;
        if (do_rst) begin
            #1 clr_n = 1'b0;
            #1 chk_all_zero("async_rst");
            #1 clr_n = 1'b1;
            model_reset();
        end
        @(posedge clk);
        model_step(vld, c, tn, r, st, fl);
        sb.push_back(snapshot(q));
    endtask

    initial begin : monitor
        exp_t e;
        int   n = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid",     64'(valid_o),     64'(e.valid));
                chk("ctrl",      64'(ctrl_o),      64'(e.ctrl));
                chk("tnew",      64'(tnew_o),      64'(e.tnew));
                chk("rd",        64'(rd_o),        64'(e.rd));
                chk("hit",       64'(hit_o),       64'(e.hit));
                chk("hit_stage", 64'(hit_stage_o), 64'(e.hit_stage));
                chk("hit_ready", 64'(hit_ready_o), 64'(e.hit_ready));
`ifdef CTRL_PIPE_PERF_EN
                chk("bubble_cnt", 64'(bubble_cnt_o), 64'(e.bcnt));
`endif
                $display("txn %0d q_rs=%0d valid=%b rd=%h tnew=%h hit=%b stage=%0d ready=%b",
                         n, q_rs, valid_o, rd_o, tnew_o, hit_o, hit_stage_o, hit_ready_o);
                n++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        in_valid = 1'b0; in_ctrl = '0; in_tnew = '0; in_rd = '0;
        stall_i = '0; flush_i = '0; q_rs = '0;
        model_reset();
        #3 chk_all_zero("reset");
        #9 clr_n = 1'b1;

        // Tnew countdown and forwarding readiness
        cycle(1'b1, 3'b010, 2, 5'd8, 3'b000, 3'b000, 5'd8, 1'b0);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b000, 3'b000, 5'd8, 1'b0);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b000, 3'b000, 5'd8, 1'b0);
        // Tnew of zero must saturate
        cycle(1'b1, 3'b010, 0, 5'd3, 3'b000, 3'b000, 5'd3, 1'b0);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b000, 3'b000, 5'd3, 1'b0);
        // Stall stage 0 twice: hold, bubble behind
        cycle(1'b1, 3'b010, 3, 5'd5, 3'b000, 3'b000, 5'd5, 1'b0);
        cycle(1'b1, 3'b111, 6, 5'd7, 3'b001, 3'b000, 5'd5, 1'b0);
        cycle(1'b1, 3'b111, 6, 5'd7, 3'b001, 3'b000, 5'd5, 1'b0);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b000, 3'b000, 5'd5, 1'b0);
        // Adjacent stalls hold together; middle stall bubbles the oldest
        cycle(1'b1, 3'b011, 4, 5'd6, 3'b000, 3'b000, 5'd6, 1'b0);
        cycle(1'b1, 3'b010, 5, 5'd4, 3'b011, 3'b000, 5'd6, 1'b0);
        cycle(1'b1, 3'b010, 5, 5'd4, 3'b010, 3'b000, 5'd4, 1'b0);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b100, 3'b000, 5'd6, 1'b0);
        // Flush wins over stall
        cycle(1'b1, 3'b010, 2, 5'd2, 3'b001, 3'b001, 5'd2, 1'b0);
        // Youngest producer, register 0, non-writing producer
        cycle(1'b1, 3'b010, 1, 5'd9, 3'b000, 3'b000, 5'd9, 1'b0);
        cycle(1'b1, 3'b010, 1, 5'd9, 3'b000, 3'b000, 5'd9, 1'b0);
        cycle(1'b1, 3'b010, 1, 5'd0, 3'b000, 3'b000, 5'd0, 1'b0);
        cycle(1'b1, 3'b010, 1, 5'd9, 3'b000, 3'b000, 5'd9, 1'b0);
        cycle(1'b1, 3'b001, 1, 5'd9, 3'b000, 3'b000, 5'd9, 1'b0);
        // Reset mid-stream, then idle inputs keep everything clear
        cycle(1'b1, 3'b010, 5, 5'd12, 3'b000, 3'b000, 5'd12, 1'b1);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b000, 3'b000, 5'd12, 1'b0);
        cycle(1'b0, 3'b000, 0, 5'd0, 3'b000, 3'b000, 5'd12, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [DEPTH-1:0] st;
            logic [DEPTH-1:0] fl;
            for (int k = 0; k < DEPTH; k++) begin
                st[k] = ($urandom_range(0, 3) == 0);
                fl[k] = ($urandom_range(0, 9) == 0);
            end
            cycle(1'($urandom_range(0, 1)), CTRL_W'($urandom), int'($urandom_range(0, 7)),
                  RD_W'($urandom_range(0, 7)), st, fl, RD_W'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) == 0));
        end

        repeat (3) @(posedge clk);
        done = 1'b1;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised multi-stage control/hazard pipeline carrying per-instruction control bits, destination register and Tnew through DEPTH back-to-back stage registers (e.g. EX/MEM, MEM/WB).
- Generalises the single MEM/WB control register with per-stage stall, per-stage flush, automatic bubble insertion behind a stalled stage, and valid tracking.
- Adds a combinational forwarding/hazard query that reports the youngest in-flight producer of a source register.
- Sits between the hazard unit and the datapath pipeline registers.

Parameters:
DEPTH, 2, number of stage registers (>=1); stage 0 is youngest.
CTRL_W, 3, control bits carried per stage.
TNEW_W, 3, width of Tnew field.
RD_W, 5, destination register index width.
REGW_BIT, 0, index within ctrl of the register-write enable bit.

Ports:
clk  input  1  clock, rising edge.
clr_n  input  1  asynchronous active-low reset.
in_valid  input  1  instruction entering stage 0 is valid.
in_ctrl  input  CTRL_W  control bits entering stage 0.
in_tnew  input  TNEW_W  Tnew of entering instruction, before decrement.
in_rd  input  RD_W  destination register of entering instruction.
stall_i  input  DEPTH  bit k: hold stage k.
flush_i  input  DEPTH  bit k: clear stage k.
q_rs  input  RD_W  source register to look up.
valid_o  output  DEPTH  per-stage valid.
ctrl_o  output  DEPTH*CTRL_W  per-stage ctrl; stage k at [k*CTRL_W +: CTRL_W].
tnew_o  output  DEPTH*TNEW_W  per-stage Tnew, same packing.
rd_o  output  DEPTH*RD_W  per-stage rd, same packing.
hit_o  output  1  some stage produces q_rs.
hit_stage_o  output  $clog2(DEPTH)+1  index of youngest producing stage; 0 when no hit.
hit_ready_o  output  1  hit stage has Tnew==0, so its value is forwardable now.

Behaviour:
- Reset: clr_n low clears every stage asynchronously: valid=0, ctrl=0, tnew=0, rd=0. All outputs go to 0 immediately and stay 0 until clr_n is released. Reset asserted mid-operation discards all stages.
- Stage k update on rising clk, first matching rule wins:
  1. flush_i[k]=1: load a bubble (valid=0, ctrl=0, tnew=0, rd=0). Flush beats stall.
  2. stall_i[k]=1: hold all fields, including Tnew; Tnew does not decrement while held.
  3. k>0 and stall_i[k-1]=1: load a bubble, because the older stage advances while the younger one is held.
  4. Otherwise load from the source stage: stage k-1, or the in_* inputs for k=0. valid, ctrl and rd are copied. tnew = src_tnew-1 if src_tnew>=1, else 0 (saturating, never wraps).
- Bubble rule: a flushed or bubbled stage always has ctrl=0, so its REGW_BIT=0.
- Latency: an instruction presented on in_* appears in stage k after k+1 unstalled cycles. Its Tnew at stage k is max(in_tnew-(k+1),0).
- Simultaneous stall_i[k] and stall_i[k+1]: both hold, no bubble. Stall on the oldest stage has no downstream effect.
- Query (combinational, no clock dependence):
  - Stage k matches when valid[k]=1, ctrl[k][REGW_BIT]=1, rd[k]==q_rs and q_rs!=0.
  - Register 0 never hits.
  - Lowest-index (youngest) match wins.
  - hit_o=0 forces hit_stage_o=0 and hit_ready_o=0.
- DEPTH=1: rule 3 never applies; hit_stage_o is 0 whenever hit_o=1.

Optional Feature:
Macro CTRL_PIPE_PERF_EN.
- Defined: adds output bubble_cnt_o [31:0]. It increments by 1 in every cycle where at least one stage takes rule 3 (stall bubble); flush bubbles are not counted. It saturates at 32'hFFFF_FFFF and clears on clr_n low.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. Reset mid-stream: fill stages, pull clr_n low without a clock edge -> all outputs 0 immediately; after release with in_valid=0 they remain 0.
2. DEPTH=2, in_tnew=2, rd=8, REGW=1, no stalls -> stage0 tnew=1 on cycle 1, stage1 tnew=0 on cycle 2. With q_rs=8: hit_stage_o=0 / hit_ready_o=0 on cycle 1, then hit_stage_o=1 / hit_ready_o=1 on cycle 2.
3. in_tnew=0 entering -> stage0 tnew=0, no wrap to 7.
4. stall_i=2'b01 for 2 cycles with stage0 holding rd=5, tnew=2 -> stage0 unchanged (tnew still 2), stage1 valid=0 / ctrl=0. With CTRL_PIPE_PERF_EN, bubble_cnt_o goes 0->2.
5. stall_i=2'b01 and flush_i=2'b01 together -> stage0 becomes a bubble; flush wins.
6. Stage0 and stage1 both hold rd=9 with REGW=1, q_rs=9 -> hit_stage_o=0. With q_rs=0 and rd=0 in flight -> hit_o=0. With REGW=0 in stage0 -> hit_stage_o=1.
